branch_ctrl: RTL



---
 rtl/branch_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch-control unit: decodes control-flow ops into the PC's branch code and
// target, owns the condition flag that drives jcnd, and keeps a hardware
// return-address stack (RAS) for CALL/RET.
module branch_ctrl #(
  parameter int unsigned D     = 12,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [2:0]    op,
  input  logic [D-1:0]  imm_target,
  input  logic [D-1:0]  pc_in,
  input  logic          flag_in,
  output logic [2:0]    branch,
  output logic [D-1:0]  target,
  output logic          jcnd,
  output logic [CW-1:0] ras_count,
  output logic          ras_full,
  output logic          ras_empty,
  output logic          err
);

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpJmp  = 3'b001,
    OpBt   = 3'b010,
    OpBf   = 3'b011,
    OpCall = 3'b100,
    OpRet  = 3'b101,
    OpSetf = 3'b110,
    OpRsvd = 3'b111
  } op_e;

  // Branch codes understood by the PC.
  localparam logic [2:0] BrSeq    = 3'b000;
  localparam logic [2:0] BrIfTrue = 3'b001;
  localparam logic [2:0] BrIfFals = 3'b010;
  localparam logic [2:0] BrAlways = 3'b011;

  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  op_e             op_dec;
  logic            flag_q, flag_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [D-1:0]    ras_q [DEPTH];
  logic [D-1:0]    ras_top;
  logic            full, empty;
  logic            push_en;
  logic [D-1:0]    push_data;

  assign op_dec = op_e'(op);
  assign full   = (count_q == CountFull);
  assign empty  = (count_q == '0);

  // Select the top-of-stack entry (entry[count-1]) without an out-of-range index.
  always_comb begin
    ras_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_q) begin
        ras_top = ras_q[i];
      end
    end
  end

  // Combinational decode to the PC: zero latency so the PC acts on the same edge.
  always_comb begin
    branch = BrSeq;
    target = '0;
    if (valid) begin
      case (op_dec)
        OpJmp: begin
          branch = BrAlways;
          target = imm_target;
        end
        OpBt: begin
          branch = BrIfTrue;
          target = imm_target;
        end
        OpBf: begin
          branch = BrIfFals;
          target = imm_target;
        end
        OpCall: begin
          // The jump happens even when the RAS is full.
          branch = BrAlways;
          target = imm_target;
        end
        OpRet: begin
          if (!empty) begin
            branch = BrAlways;
            target = ras_top;
          end
        end
        default: begin
          branch = BrSeq;
          target = '0;
        end
      endcase
    end
  end

  // Next-state for flag, error and stack occupancy.
  always_comb begin
    flag_d    = flag_q;
    err_d     = err_q;
    count_d   = count_q;
    push_en   = 1'b0;
    push_data = pc_in + 1'b1;  // wraps modulo 2^D
    if (valid) begin
      case (op_dec)
        OpSetf: flag_d = flag_in;
        OpCall: begin
          if (full) begin
            err_d = 1'b1;  // overflow drops the new entry, oldest entries kept
          end else begin
            push_en = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        OpRet: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset wins over any op presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      flag_q  <= flag_d;
      err_q   <= err_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_en && (CW'(i) == count_q)) begin
          ras_q[i] <= push_data;
        end
      end
    end
  end

  assign jcnd      = flag_q;
  assign err       = err_q;
  assign ras_count = count_q;
  assign ras_full  = full;
  assign ras_empty = empty;

endmodule
